// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the core data port and a word-wide, byte-enable-less
// data memory. One request in flight; sub-word stores use read-modify-write.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DATA,
        WR,
        RESP
    } state_t;

    // Captured request; only the low halfword of store data is needed for RMW
    typedef struct packed {
        logic              write;
        logic [2:0]        funct3;
        logic [1:0]        lane;
        logic [HALF_W-1:0] wdata;
    } req_t;

    state_t              state;
    state_t              state_next;
    req_t                cur;
    logic                accept_c;
    logic                err_c;
    logic [4:0]          byte_ofs_c;
    logic [4:0]          half_ofs_c;
    logic [BYTE_W-1:0]   byte_v_c;
    logic [HALF_W-1:0]   half_v_c;
    logic [DATA_W-1:0]   load_c;
    logic [DATA_W-1:0]   merge_c;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    // Handshake and write strobe are gated by reset directly
    assign req_ready = (state == IDLE) & ~rst;
    assign mem_we    = (state == WR) & ~rst;
    assign accept_c  = req_valid & req_ready;

    // Unsupported funct3, sub-word stores marked unsigned, or misalignment
    function automatic logic is_err(input logic wr, input logic [2:0] f3, input logic [1:0] a);
        logic e;
        e = 1'b0;
        case (f3)
            3'b000:          e = 1'b0;
            3'b001:          e = a[0];
            3'b010:          e = (a != 2'b00);
            3'b100, 3'b101:  e = wr | (f3[0] & a[0]);
            default:         e = 1'b1;
        endcase
        return e;
    endfunction

    assign err_c = is_err(req_write, req_funct3, req_addr[1:0]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (err_c) begin
                        state_next = RESP;
                    end else if (req_write && (req_funct3 == 3'b010)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = DATA;
            DATA:    state_next = cur.write ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores
    always_comb begin
        byte_ofs_c = {cur.lane, 3'b000};
        half_ofs_c = {cur.lane[1], 4'b0000};
        byte_v_c   = mem_dout[byte_ofs_c +: BYTE_W];
        half_v_c   = mem_dout[half_ofs_c +: HALF_W];
        case (cur.funct3)
            3'b000:  load_c = {{(DATA_W-BYTE_W){byte_v_c[BYTE_W-1]}}, byte_v_c};
            3'b100:  load_c = {{(DATA_W-BYTE_W){1'b0}}, byte_v_c};
            3'b001:  load_c = {{(DATA_W-HALF_W){half_v_c[HALF_W-1]}}, half_v_c};
            3'b101:  load_c = {{(DATA_W-HALF_W){1'b0}}, half_v_c};
            default: load_c = mem_dout;
        endcase
        merge_c = mem_dout;
        if (cur.funct3[1:0] == 2'b00) begin
            merge_c[byte_ofs_c +: BYTE_W] = cur.wdata[BYTE_W-1:0];
        end else begin
            merge_c[half_ofs_c +: HALF_W] = cur.wdata;
        end
    end

    // Request capture, memory address/data and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            resp_valid <= (state_next == RESP);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        cur <= '{write:  req_write,
                                 funct3: req_funct3,
                                 lane:   req_addr[1:0],
                                 wdata:  req_wdata[HALF_W-1:0]};
                        if (err_c) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_din  <= req_wdata;
                        end
                    end
                end
                DATA: begin
                    if (cur.write) begin
                        mem_din <= merge_c;
                    end else begin
                        resp_rdata <= load_c;
                        resp_err   <= 1'b0;
                    end
                end
                WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
